fp_matrix_writeback: RTL and testbench
======================================

Name: fp_matrix_writeback

Overview:
- Avalon-MM write master that copies an N×N single-precision matrix from on-chip RAM back to SDRAM.
- Write-direction counterpart of the determinant unit's SDRAM load path. Used to return LU-decomposed or result matrices to the Nios.
- Started through a custom-instruction-style start/done port; signals completion via irq, cleared by a slave-side acknowledge.

Parameters:
ADDR_W, 24, Avalon master byte address width
RAM_AW, 10, on-chip RAM word address width
MAX_DIMENSION, 32, largest accepted matrix dimension
DEFAULT_DIMENSION, 16, dimension used when datab is 0
ST_BUSY, 1, status code: busy writing
ST_IRQ, 3, status code: waiting for irq acknowledge
ST_ACCEPT, 99, status code: start accepted
ST_REJECT, 100, status code: start rejected (bad dimension)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  custom-instruction start strobe
dataa  in  32  SDRAM byte base address; bits [ADDR_W-1:0] used, [1:0] forced to 0
datab  in  32  matrix dimension; 0 selects DEFAULT_DIMENSION
done  out  1  one-cycle response to start
result  out  32  status code returned with done
ram_rdaddress  out  RAM_AW  on-chip RAM read address
ram_rden  out  1  RAM read enable
ram_q  in  32  RAM read data, valid exactly 1 cycle after ram_rden
avm_address  out  ADDR_W  Avalon write address
avm_write  out  1  Avalon write request
avm_writedata  out  32  Avalon write data
avm_waitrequest  in  1  Avalon stall
irq  out  1  completion interrupt, level
irq_ack  in  1  slave-side read of completion register; clears irq

Behaviour:
- Reset: done=0, result=0, ram_rden=0, ram_rdaddress=0, avm_write=0, avm_address=0, avm_writedata=0, irq=0, state=IDLE, FIFO empty, counters 0.
- Reset mid-transfer aborts immediately; avm_write drops next cycle regardless of avm_waitrequest.
- States:
  - IDLE → WRITE on an accepted start.
  - WRITE → IRQ when the last word is accepted (avm_write && !avm_waitrequest on word N-1).
  - IRQ → IDLE on irq_ack.
- Start handling, registered; done/result appear the cycle after start:
  - IDLE, dimension d in 1..MAX_DIMENSION (d = datab[5:0], or DEFAULT if datab==0): accept; result=ST_ACCEPT.
  - IDLE, datab > MAX_DIMENSION: result=ST_REJECT; no transfer.
  - WRITE: result=ST_BUSY, ignored.
  - IRQ: result=ST_IRQ, ignored.
  - done is high for exactly 1 cycle; otherwise done=0, result=0.
- Word count N = d*d, computed at accept into an 11-bit register (max 1024).
- Word k is read from RAM address k and written to base + 4*k. Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- Prefetch: 2-entry FIFO between RAM and Avalon.
  - Issue ram_rden with next read index when (FIFO occupancy + reads in flight) < 2 and read index < N.
  - The ram_q word is pushed the cycle after ram_rden.
- Avalon side:
  - avm_write = FIFO non-empty; avm_writedata = FIFO head; avm_address = base + 4*write index.
  - Pop and increment write index on avm_write && !avm_waitrequest.
  - address and data are held stable while avm_waitrequest is high.
- Throughput: 1 word/cycle when waitrequest is low. First avm_write is 2 cycles after the accept cycle (1 RAM latency + 1 register).
- Simultaneous push and pop keeps occupancy constant. FIFO never overflows by the credit rule above.
- irq rises the cycle after the final word is accepted and stays high until irq_ack. irq_ack outside IRQ is ignored.

Decomposition:
- Shared package fp_det_pkg: status code constants (0, 1, 2, 3, 99, 100), FLOAT_ONE, NaN, MAX_DIMENSION, DEFAULT_DIMENSION. The determinant core uses the same package.
- One sub-module, wb_prefetch_fifo: 2-deep, 32-bit, push/pop/occupancy, synchronous reset.
- FSM, counters and credit logic live in the top module.

Test Plan:
- dataa=0x001000, datab=2, RAM[0..3]=A,B,C,D, waitrequest=0 → done with result 99. Then 4 consecutive writes to 0x1000/4/8/C with A..D. irq=1 the cycle after the 4th write.
- Same as above with waitrequest high 3 cycles on word 1 and alternate cycles thereafter → writes in order A..D with no duplicates or drops; address and data are stable during stalls.
- datab=0 → 256 writes from base to base+0x3FC; after irq_ack, irq=0 and state IDLE. A new start then returns 99.
- datab=33 → done with result 100; avm_write stays 0; irq stays 0.
- start while writing → result 1. start while irq pending → result 3. The ongoing transfer is unaffected.
- reset asserted on word 5 of 16 → avm_write=0 and irq=0 next cycle. A fresh start then completes a full 16-word transfer from word 0.

Source files
------------

// File: rtl/fp_det_pkg.sv
// Constants and types shared by the determinant core and its SDRAM load/writeback masters.
package fp_det_pkg;

    localparam logic [31:0] ST_IDLE    = 32'd0;
    localparam logic [31:0] ST_BUSY    = 32'd1;
    localparam logic [31:0] ST_LOADING = 32'd2;
    localparam logic [31:0] ST_IRQ     = 32'd3;
    localparam logic [31:0] ST_ACCEPT  = 32'd99;
    localparam logic [31:0] ST_REJECT  = 32'd100;

    localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;
    localparam logic [31:0] FLOAT_NAN = 32'h7FC0_0000;

    localparam int MAX_DIMENSION     = 32;
    localparam int DEFAULT_DIMENSION = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_IRQ
    } wb_state_e;

    // d*d for d <= 32 needs 11 bits (1024 words).
    function automatic logic [10:0] word_count(input logic [5:0] dim);
        return 11'(dim) * 11'(dim);
    endfunction

endpackage

// File: rtl/fp_matrix_writeback_fifo.sv
// Two-entry prefetch FIFO decoupling RAM read latency from Avalon write stalls.
module wb_prefetch_fifo (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic [31:0] head_o,
    output logic [1:0]  count_o,
    output logic        empty_o
);

    logic [31:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // NOTE: the storage is reset as well, because the head drives avm_writedata
    // directly and must read as zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fp_matrix_writeback.sv
// Avalon-MM write master copying an NxN float matrix from on-chip RAM back to SDRAM,
// started via a custom-instruction start/done handshake and finished with a level irq.
module fp_matrix_writeback
    import fp_det_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    output logic              done,
    output logic [31:0]       result,
    output logic [RAM_AW-1:0] ram_rdaddress,
    output logic              ram_rden,
    input  logic [31:0]       ram_q,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic              irq,
    input  logic              irq_ack
);

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [10:0]       n_q, n_d;
    logic [10:0]       rd_idx_q, rd_idx_d;
    logic [10:0]       wr_idx_q, wr_idx_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic [31:0]       result_q, result_d;

    logic              fifo_pop;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [31:0]       fifo_head;
    logic [5:0]        dim;
    logic              dim_ok;
    logic [2:0]        credit_used;
    logic              rd_issue;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{dataa[31:ADDR_W], dataa[1:0]};

    assign dim    = (datab == 32'd0) ? 6'(DEFAULT_DIMENSION) : datab[5:0];
    assign dim_ok = (datab <= 32'(MAX_DIMENSION));

    assign fifo_pop = !fifo_empty && !avm_waitrequest;

    // The pop of this cycle frees a slot in time for the read issued now, which is
    // what sustains one word per cycle through a two-entry FIFO.
    assign credit_used = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
    assign rd_issue    = (state_q == S_WRITE) && (rd_idx_q < n_q) && (credit_used < 3'd2);

    // NOTE: every signal written here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        n_d        = n_q;
        rd_idx_d   = rd_idx_q + 11'(rd_issue);
        wr_idx_d   = wr_idx_q + 11'(fifo_pop);
        inflight_d = rd_issue;
        done_d     = start;
        result_d   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dim_ok) begin
                        result_d = ST_ACCEPT;
                        state_d  = S_WRITE;
                        base_d   = {dataa[ADDR_W-1:2], 2'b00};
                        n_d      = word_count(dim);
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                    end else begin
                        result_d = ST_REJECT;
                    end
                end
            end
            S_WRITE: begin
                if (start) result_d = ST_BUSY;
                if (fifo_pop && (wr_idx_q == n_q - 11'd1)) state_d = S_IRQ;
            end
            S_IRQ: begin
                if (start) result_d = ST_IRQ;
                if (irq_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            n_q        <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            n_q        <= n_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    wb_prefetch_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (ram_q),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign ram_rden      = rd_issue;
    assign ram_rdaddress = RAM_AW'(rd_idx_q);
    assign avm_write     = !fifo_empty;
    assign avm_writedata = fifo_head;
    assign avm_address   = base_q + ADDR_W'({wr_idx_q, 2'b00});
    assign irq           = (state_q == S_IRQ);
    assign done          = done_q;
    assign result        = result_q;

endmodule

// File: tb/tb_fp_matrix_writeback.sv
// Directed bench for fp_matrix_writeback: vector table plus busy/irq and mid-transfer reset sequences.
module tb_fp_matrix_writeback;

    localparam int ADDR_W = 24;
    localparam int RAM_AW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [31:0]       dataa;
    logic [31:0]       datab;
    logic              done;
    logic [31:0]       result;
    logic [RAM_AW-1:0] ram_rdaddress;
    logic              ram_rden;
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;
    logic              irq;
    logic              irq_ack;

    fp_matrix_writeback #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .dataa           (dataa),
        .datab           (datab),
        .done            (done),
        .result          (result),
        .ram_rdaddress   (ram_rdaddress),
        .ram_rden        (ram_rden),
        .ram_q           (ram_q),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .irq             (irq),
        .irq_ack         (irq_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ram [1024];
    always @(posedge clk) if (ram_rden) ram_q <= ram[ram_rdaddress];

    logic [ADDR_W-1:0] got_addr [$];
    logic [31:0]       got_data [$];
    int                got_cyc  [$];
    int                stall_viol   = 0;
    int                stall_checks = 0;
    int                wr_hi_cnt    = 0;
    logic              prev_stall   = 1'b0;
    logic [ADDR_W-1:0] prev_addr    = '0;
    logic [31:0]       prev_data    = '0;

    always @(negedge clk) begin
        if (!reset && prev_stall) begin
            stall_checks <= stall_checks + 1;
            if (!avm_write || avm_address != prev_addr || avm_writedata != prev_data)
                stall_viol <= stall_viol + 1;
        end
        prev_stall <= !reset && avm_write && avm_waitrequest;
        prev_addr  <= avm_address;
        prev_data  <= avm_writedata;
        if (!reset && avm_write) wr_hi_cnt <= wr_hi_cnt + 1;
        if (!reset && avm_write && !avm_waitrequest) begin
            got_addr.push_back(avm_address);
            got_data.push_back(avm_writedata);
            got_cyc.push_back(cyc);
        end
    end

    int wait_mode = 0;
    int got_base  = 0;

    initial begin
        int acc;
        int stall_run;
        logic tog;
        avm_waitrequest = 1'b0;
        stall_run = 0;
        tog = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            acc = got_addr.size() - got_base;
            if (wait_mode == 0) begin
                avm_waitrequest = 1'b0;
                stall_run = 0;
                tog = 1'b0;
            end else if (acc == 1) begin
                avm_waitrequest = avm_write && (stall_run < 3);
                if (avm_write && stall_run < 3) stall_run++;
            end else if (acc >= 2) begin
                tog = !tog;
                avm_waitrequest = tog;
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    typedef struct {
        logic [31:0] dataa;
        logic [31:0] datab;
        int          wait_mode;
        logic [31:0] exp_result;
        int          exp_words;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input string nm, output int dc);
        @(posedge clk); #1;
        start = 1'b1; dataa = a; datab = b;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        dc = cyc;
        check({nm, " done"}, 64'(done), 64'd1);
        check({nm, " result"}, 64'(result), 64'(exp_res));
        @(negedge clk);
        check({nm, " done one cycle"}, 64'(done), 64'd0);
    endtask

    task automatic run_vector(input vec_t v, input bit poke, input string nm);
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] exp_addr;
        int dc, dc2, irq_cyc, last, first, nwords, bad_words, sv0, sc0, wh0;
        bit irq_seen;
        sv0 = stall_viol; sc0 = stall_checks; wh0 = wr_hi_cnt;
        wait_mode = v.wait_mode;
        got_base  = got_addr.size();
        base      = {v.dataa[ADDR_W-1:2], 2'b00};
        do_start(v.dataa, v.datab, v.exp_result, nm, dc);
        if (v.exp_words == 0) begin
            repeat (20) @(negedge clk);
            check({nm, " no writes"}, 64'(wr_hi_cnt - wh0), 64'd0);
            check({nm, " irq stays low"}, 64'(irq), 64'd0);
        end else begin
            if (poke) begin
                repeat (2) @(negedge clk);
                @(posedge clk); #1; irq_ack = 1'b1;
                @(posedge clk); #1; irq_ack = 1'b0;
                do_start(32'h0000_5000, 32'd2, 32'd1, {nm, " busy"}, dc2);
            end
            irq_seen = 1'b0;
            for (int i = 0; i < v.exp_words * 4 + 100; i++) begin
                if (irq) begin
                    irq_seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            irq_cyc = cyc;
            check({nm, " irq raised"}, 64'(irq_seen), 64'd1);
            if (poke) begin
                do_start(32'h0000_5000, 32'd2, 32'd3, {nm, " irq pending"}, dc2);
                check({nm, " irq held"}, 64'(irq), 64'd1);
            end
            nwords = got_addr.size() - got_base;
            check({nm, " word count"}, 64'(nwords), 64'(v.exp_words));
            bad_words = 0;
            for (int k = 0; k < nwords && k < v.exp_words; k++) begin
                exp_addr = base + ADDR_W'(4 * k);
                if (got_addr[got_base + k] !== exp_addr || got_data[got_base + k] !== ram[k]) begin
                    if (bad_words == 0)
                        $display("FAIL %s word %0d: got %0h/%0h expected %0h/%0h", nm, k,
                                 got_addr[got_base + k], got_data[got_base + k], exp_addr, ram[k]);
                    bad_words++;
                end
            end
            check({nm, " bad words"}, 64'(bad_words), 64'd0);
            if (nwords > 0) begin
                first = got_cyc[got_base];
                last  = got_cyc[got_base + nwords - 1];
                check({nm, " irq one cycle after last"}, 64'(irq_cyc), 64'(last + 1));
                if (v.wait_mode == 0 && !poke) begin
                    check({nm, " first write latency"}, 64'(first), 64'(dc + 2));
                    check({nm, " back-to-back"}, 64'(last - first), 64'(v.exp_words - 1));
                end
            end
            if (v.wait_mode != 0)
                check({nm, " stalls seen"}, 64'(stall_checks - sc0 > 0), 64'd1);
            @(posedge clk); #1; irq_ack = 1'b1;
            @(posedge clk); #1; irq_ack = 1'b0;
            @(negedge clk);
            check({nm, " irq cleared"}, 64'(irq), 64'd0);
        end
        check({nm, " stable under stall"}, 64'(stall_viol - sv0), 64'd0);
        wait_mode = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dc;
        vec_t v;
        start = 1'b0; dataa = '0; datab = '0; irq_ack = 1'b0; reset = 1'b1;
        for (int k = 0; k < 1024; k++) ram[k] = 32'h1234_5678 + 32'(k) * 32'h9E37_79B9;

        vecs[0] = '{32'h0000_1000, 32'd2,  0, 32'd99,  4};
        vecs[1] = '{32'h0000_1000, 32'd2,  1, 32'd99,  4};
        vecs[2] = '{32'h0000_4000, 32'd0,  0, 32'd99,  256};
        vecs[3] = '{32'h0000_1000, 32'd33, 0, 32'd100, 0};
        vecs[4] = '{32'hAB00_0100, 32'd1,  0, 32'd99,  1};
        vecs[5] = '{32'h00FF_FFF3, 32'd3,  1, 32'd99,  9};
        vecs[6] = '{32'h0000_0000, 32'd32, 0, 32'd99,  1024};
        vecs[7] = '{32'h0000_1000, 32'd64, 0, 32'd100, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst done", 64'(done), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst ram_rden", 64'(ram_rden), 64'd0);
        check("rst ram_rdaddress", 64'(ram_rdaddress), 64'd0);
        check("rst avm_write", 64'(avm_write), 64'd0);
        check("rst avm_address", 64'(avm_address), 64'd0);
        check("rst avm_writedata", 64'(avm_writedata), 64'd0);
        check("rst irq", 64'(irq), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vector(vecs[i], 1'b0, $sformatf("vec%0d", i));

        v = '{32'h0000_3000, 32'd4, 0, 32'd99, 16};
        run_vector(v, 1'b1, "poke");

        got_base = got_addr.size();
        do_start(32'h0000_2000, 32'd4, 32'd99, "rst_mid", dc);
        for (int i = 0; i < 100 && (got_addr.size() - got_base) < 5; i++) @(negedge clk);
        check("rst_mid reached word 5", 64'(got_addr.size() - got_base >= 5), 64'd1);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid avm_write", 64'(avm_write), 64'd0);
        check("rst_mid irq", 64'(irq), 64'd0);
        check("rst_mid ram_rden", 64'(ram_rden), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        v = '{32'h0000_2000, 32'd4, 0, 32'd99, 16};
        run_vector(v, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
